// File: rtl/irq_dispatch_arbiter.sv
// irq_dispatch_arbiter
// Hands pending interrupt lines to the core one at a time. Each request runs
// a req/id handshake until the core acks. A one-cycle clear pulse then goes back
// to the service unit. A request is dropped when its line is withdrawn, or
// after ACK_TIMEOUT cycles without an ack.
module irq_dispatch_arbiter #(
  parameter int NUM_IRQ     = 32,
  parameter int ID_WIDTH    = 5,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [NUM_IRQ-1:0]  irq_pending_i,
  input  logic [NUM_IRQ-1:0]  irq_mask_i,
  input  logic                rr_mode_i,
  output logic                core_irq_req_o,
  output logic [ID_WIDTH-1:0] core_irq_id_o,
  input  logic                core_irq_ack_i,
  output logic [NUM_IRQ-1:0]  irq_clear_o,
  output logic                timeout_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // A zero ACK_TIMEOUT disables the abandon path entirely.
  localparam bit                  TIMEOUT_EN   = (ACK_TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [ID_WIDTH:0]    NUM_IRQ_W    = (ID_WIDTH+1)'(NUM_IRQ);
  localparam logic [ID_WIDTH-1:0]  LAST_ID      = ID_WIDTH'(NUM_IRQ - 1);

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  logic [NUM_IRQ-1:0]    eligible_s;
  logic [ID_WIDTH-1:0]   fixed_id_s;
  logic [ID_WIDTH-1:0]   rr_id_s;
  logic [ID_WIDTH:0]     rr_idx_s;
  logic [ID_WIDTH-1:0]   next_ptr_s;
  logic [NUM_IRQ-1:0]    one_hot_s;

  // Winner selection: scan downward so the last hit is the lowest index,
  // or the first index at or after rr_ptr in round-robin mode.
  always_comb begin
    eligible_s = irq_pending_i & ~irq_mask_i;
    fixed_id_s = '0;
    rr_id_s    = '0;
    rr_idx_s   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      fixed_id_s = eligible_s[ID_WIDTH'(i)] ? ID_WIDTH'(i) : fixed_id_s;
      rr_idx_s   = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(i);
      if (rr_idx_s >= NUM_IRQ_W) begin
        rr_idx_s = rr_idx_s - NUM_IRQ_W;
      end else begin
        rr_idx_s = rr_idx_s;
      end
      rr_id_s = eligible_s[rr_idx_s[ID_WIDTH-1:0]] ? rr_idx_s[ID_WIDTH-1:0] : rr_id_s;
    end
  end

  // Round-robin pointer successor of the served id, wrapping at the last line.
  always_comb begin
    if (id_q == LAST_ID) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = id_q + ID_WIDTH'(1);
    end
    one_hot_s = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id_q;
  end

  // State register: all flops, synchronous active-high reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: ack beats withdrawal, withdrawal beats timeout.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible_s) begin
          state_d = ST_REQ;
          id_d    = rr_mode_i ? rr_id_s : fixed_id_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (core_irq_ack_i) begin
          state_d = ST_CLEAR;
        end else if (!irq_pending_i[id_q]) begin
          state_d = ST_IDLE;
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          rr_ptr_d  = next_ptr_s;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_CLEAR: begin
        state_d  = ST_IDLE;
        rr_ptr_d = next_ptr_s;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: purely from registered state and flags.
  always_comb begin
    core_irq_req_o = (state_q == ST_REQ);
    busy_o         = (state_q != ST_IDLE);
    core_irq_id_o  = id_q;
    timeout_o      = timeout_q;
    if (state_q == ST_CLEAR) begin
      irq_clear_o = one_hot_s;
    end else begin
      irq_clear_o = '0;
    end
  end

endmodule

// File: tb/tb_irq_dispatch_arbiter.sv
// Testbench for irq_dispatch_arbiter (NUM_IRQ=32, ACK_TIMEOUT=4).
// A transaction-level reference model predicts req/clear/timeout events into a
// scoreboard queue. A negedge monitor pops the queue and compares it with what
// the DUT shows.
module tb_irq_dispatch_arbiter;

  localparam int N = 32;
  localparam int T = 4;
  localparam int EV_REQ = 0;
  localparam int EV_CLR = 1;
  localparam int EV_TO  = 2;

  typedef struct {
    int kind;
    int id;
    int cyc;
  } ev_t;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [N-1:0]  pend;
  logic [N-1:0]  mask;
  logic          rr;
  logic          ack;
  logic          req;
  logic [4:0]    id_o;
  logic [N-1:0]  clr;
  logic          tmo;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // reference model state (transaction view)
  bit  m_hold = 1'b0;  // a request is outstanding at the core
  bit  m_clr  = 1'b0;  // the clear pulse of an accepted request is showing
  int  m_age  = 0;     // cycles the current request has been shown
  int  m_id   = 0;
  int  m_rr   = 0;
  int  cyc    = 0;
  bit  exp_req  = 1'b0;
  bit  exp_busy = 1'b0;
  ev_t sb[$];

  // observation counters (filled by the monitor from DUT outputs)
  int  obs_ids[$];
  int  obs_clr = 0;
  int  obs_to  = 0;
  int  obs_req_cyc = 0;
  bit  prev_req = 1'b0;
  int  cur_id = 0;

  always #5 HCLK = ~HCLK;

  irq_dispatch_arbiter #(
    .NUM_IRQ(N), .ID_WIDTH(5), .ACK_TIMEOUT(T), .CNT_WIDTH(16)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .irq_pending_i(pend),
    .irq_mask_i(mask),
    .rr_mode_i(rr),
    .core_irq_req_o(req),
    .core_irq_id_o(id_o),
    .core_irq_ack_i(ack),
    .irq_clear_o(clr),
    .timeout_o(tmo),
    .busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pick(input logic [N-1:0] elig, input bit rr_m, input int ptr);
    for (int i = 0; i < N; i++) begin
      int k;
      k = rr_m ? (ptr + i) % N : i;
      if (elig[k]) return k;
    end
    return -1;
  endfunction

  function automatic int obs_at(input int i);
    if (i < obs_ids.size()) return obs_ids[i];
    return -1;
  endfunction

  // Advance the reference one clock using the inputs applied for that edge.
  task automatic model_step();
    ev_t e;
    int  w;
    cyc++;
    if (HRESET) begin
      m_hold = 1'b0; m_clr = 1'b0; m_age = 0; m_rr = 0; m_id = 0;
    end else if (m_clr) begin
      m_rr  = (m_id + 1) % N;
      m_clr = 1'b0;
    end else if (m_hold) begin
      if (ack) begin
        m_hold = 1'b0; m_clr = 1'b1;
        e.kind = EV_CLR; e.id = m_id; e.cyc = cyc; sb.push_back(e);
      end else if (!pend[m_id]) begin
        m_hold = 1'b0;
      end else if (m_age == T - 1) begin
        m_hold = 1'b0;
        m_rr   = (m_id + 1) % N;
        e.kind = EV_TO; e.id = m_id; e.cyc = cyc; sb.push_back(e);
      end else begin
        m_age++;
      end
    end else begin
      w = pick(pend & ~mask, rr, m_rr);
      if (w >= 0) begin
        m_id = w; m_hold = 1'b1; m_age = 0;
        e.kind = EV_REQ; e.id = w; e.cyc = cyc; sb.push_back(e);
      end
    end
    exp_req  = m_hold;
    exp_busy = m_hold || m_clr;
  endtask

  task automatic cycle();
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic settle();
    @(negedge HCLK);
    #1;
  endtask

  task automatic reset_obs();
    obs_ids.delete();
    obs_clr = 0; obs_to = 0; obs_req_cyc = 0;
  endtask

  // Run n cycles; ack the request when it has been shown ack_delay cycles
  // (negative = never); optionally drop a line once its clear pulse is out.
  task automatic run_auto(input int n, input int ack_delay, input bit auto_clr);
    for (int i = 0; i < n; i++) begin
      ack = (ack_delay >= 0) && m_hold && (m_age == ack_delay);
      if (auto_clr && m_clr) pend[m_id] = 1'b0;
      cycle();
    end
    ack = 1'b0;
  endtask

  task automatic take(input int kind, output int id);
    ev_t e;
    id = -1;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("event_kind", e.kind, kind);
      id = e.id;
    end else begin
      note_fail("unexpected_event", kind, -1);
    end
  endtask

  // Monitor: per-cycle state checks plus scoreboard matching of events.
  always @(negedge HCLK) begin
    int  id;
    bit  start;
    logic [31:0] one;
    one = 32'd1;
    chk("req", {31'd0, req}, {31'd0, exp_req});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      note_fail("missed_event", -1, sb[0].kind);
      void'(sb.pop_front());
    end
    start = req && !prev_req;
    if (clr != '0) begin
      obs_clr++;
      take(EV_CLR, id);
      if (id >= 0) chk("clear_vec", clr, one << id);
    end
    if (tmo) begin
      obs_to++;
      take(EV_TO, id);
    end
    if (start) begin
      obs_ids.push_back(int'(id_o));
      take(EV_REQ, id);
      if (id >= 0) begin
        chk("req_id", {27'd0, id_o}, id);
        cur_id = id;
      end
    end else if (req) begin
      chk("id_stable", {27'd0, id_o}, cur_id);
    end
    if (req) obs_req_cyc++;
    prev_req = req;
  end

  initial begin
    HRESET = 1'b1; pend = '0; mask = '0; rr = 1'b0; ack = 1'b0;
    cycle(); cycle();
    settle();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_id", {27'd0, id_o}, 32'd0);
    chk("rst_clear", clr, 32'd0);
    chk("rst_timeout", {31'd0, tmo}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    HRESET = 1'b0;

    // fixed priority, two lines, ack two cycles after req
    reset_obs();
    pend = 32'h0000_0014;
    run_auto(20, 2, 1'b1);
    settle();
    chk("fixed_count", obs_ids.size(), 32'd2);
    chk("fixed_first", obs_at(0), 32'd2);
    chk("fixed_second", obs_at(1), 32'd4);
    chk("fixed_clears", obs_clr, 32'd2);

    // round robin, two lines held, every request acked
    reset_obs();
    rr = 1'b1; pend = 32'h0000_0003;
    run_auto(11, 0, 1'b0);
    pend = '0;
    run_auto(6, 0, 1'b0);
    settle();
    chk("rr_count", obs_ids.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_seq", obs_at(i), i % 2);

    // round robin wrap from line 31 back to 0 (pointer sits at 2 here)
    reset_obs();
    pend = 32'h8000_0001;
    run_auto(11, 0, 1'b0);
    pend = '0;
    run_auto(6, 0, 1'b0);
    settle();
    chk("wrap_count", obs_ids.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("wrap_seq", obs_at(i), (i % 2 == 0) ? 32'd31 : 32'd0);

    // masked line 0 is never requested
    reset_obs();
    rr = 1'b0; mask = 32'h0000_0001; pend = 32'h0000_0003;
    run_auto(12, 1, 1'b0);
    pend = '0;
    run_auto(4, 0, 1'b0);
    mask = '0;
    settle();
    chk("mask_some", obs_ids.size() >= 2, 32'd1);
    for (int i = 0; i < obs_ids.size(); i++) chk("mask_id", obs_at(i), 32'd1);

    // no ack: req held exactly T cycles, one timeout, no clear, re-arbitration
    reset_obs();
    pend = 32'h0000_0008;
    run_auto(5, -1, 1'b0);
    settle();
    chk("to_req_cycles", obs_req_cyc, T);
    chk("to_pulses", obs_to, 32'd1);
    chk("to_clears", obs_clr, 32'd0);
    run_auto(1, -1, 1'b0);
    settle();
    chk("to_rearb", obs_ids.size(), 32'd2);
    pend = '0;
    run_auto(3, -1, 1'b0);

    // withdrawal during req: back to idle, nothing pulsed
    reset_obs();
    pend = 32'h0000_0020;
    run_auto(2, -1, 1'b0);
    pend = '0;
    run_auto(3, -1, 1'b0);
    settle();
    chk("wd_clears", obs_clr, 32'd0);
    chk("wd_timeouts", obs_to, 32'd0);
    chk("wd_reqs", obs_ids.size(), 32'd1);

    // ack in final timeout cycle: clear wins
    reset_obs();
    pend = 32'h0000_0040;
    run_auto(8, T - 1, 1'b1);
    settle();
    chk("late_ack_clears", obs_clr, 32'd1);
    chk("late_ack_timeouts", obs_to, 32'd0);

    // reset while in REQ
    rr = 1'b1; pend = 32'h0000_0003;
    cycle();
    HRESET = 1'b1;
    cycle();
    HRESET = 1'b0;
    settle();
    chk("rstreq_req", {31'd0, req}, 32'd0);
    chk("rstreq_busy", {31'd0, busy}, 32'd0);
    chk("rstreq_clear", clr, 32'd0);
    // reset while in CLEAR: pointer must stay at 0
    cycle();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    HRESET = 1'b1;
    cycle();
    HRESET = 1'b0;
    settle();
    chk("rstclr_clear", clr, 32'd0);
    chk("rstclr_busy", {31'd0, busy}, 32'd0);
    chk("rstclr_id", {27'd0, id_o}, 32'd0);
    reset_obs();
    run_auto(2, -1, 1'b0);
    settle();
    chk("rstclr_ptr", obs_at(0), 32'd0);
    pend = '0;
    run_auto(3, -1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      HRESET = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) pend = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 19) == 0) mask = $urandom & $urandom;
      if ($urandom_range(0, 49) == 0) rr = ~rr;
      if (m_clr) pend[m_id] = 1'b0;
      ack = m_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      cycle();
    end
    HRESET = 1'b0; pend = '0; ack = 1'b0;
    run_auto(10, -1, 1'b0);
    settle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
